cp0: RTL
========

# cp0

Coprocessor-0 for the pipelined MIPS core. It is the producer end of the fetch-redirect interface that the PC consumes: it raises `Req` to vector fetch to 0x0000_4180 and supplies `EPCOut` for `eret`. It sits beside the M stage. It latches exception and interrupt state at the clock edge on which the PC redirects, and it services `mtc0`/`mfc0` accesses to SR(12), Cause(13), EPC(14) and PRId(15).

## Interface
- `PRID`, default 32'h0000_2024: constant value read from register 15.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `en` input 1: `mtc0` write enable from M stage.
- `CP0Add` input 5: register number for `mtc0`/`mfc0`.
- `CP0In` input 32: `mtc0` write data.
- `VPC` input 32: PC of the instruction currently in M (victim PC).
- `BDIn` input 1: the M instruction is in a branch delay slot.
- `ExcCodeIn` input 5: pipelined exception code of the M instruction; 0 means none.
- `HWInt` input 6: external interrupt lines, level-sensitive.
- `EXLClr` input 1: `eret` in M.
- `CP0Out` output 32: `mfc0` read data (combinational).
- `EPCOut` output 32: current EPC register, drives PC on ERET.
- `Req` output 1: redirect request to PC and pipeline flush (combinational).

## Operation
- State fields:
  - SR: IM[15:10], EXL[1], IE[0]. All other bits read 0.
  - Cause: BD[31], IP[15:10], ExcCode[6:2]. All other bits read 0.
  - EPC: 32 bits.
- IntReq = !EXL & IE & |(HWInt & IM).
- ExcReq = !EXL & (ExcCodeIn != 0).
- Req = IntReq | ExcReq.
- Priority: an interrupt wins over a synchronous exception in the same cycle. ExcCode is then 0 (Int) and `ExcCodeIn` is discarded.
- Every edge: Cause.IP <= HWInt, regardless of other events.
- Edge with Req=1:
  - EXL <= 1.
  - BD <= BDIn.
  - ExcCode <= IntReq ? 0 : ExcCodeIn.
  - EPC <= BDIn ? VPC-4 : VPC, 32-bit modular arithmetic.
  - A concurrent `mtc0` and `EXLClr` are ignored.
- Edge with Req=0 and EXLClr=1: EXL <= 0. If `en` is also set, the `mtc0` still applies, and an `mtc0` to SR wins on the EXL bit.
- `mtc0` (en=1, Req=0):
  - CP0Add=12: writes IM, EXL, IE from the same bit positions of CP0In.
  - CP0Add=14: writes all 32 bits of EPC.
  - Cause, PRId and other addresses are read-only; the write is dropped.
- `mfc0`: CP0Out = SR / Cause / EPC / PRID for CP0Add 12/13/14/15, else 0.
- Reads reflect the registered state before any write at the same edge. There is no write-through bypass; the hazard unit stalls `mfc0` behind `mtc0`.
- While EXL=1, Req is held 0. This covers nested interrupts and exceptions, including a faulting instruction inside the handler.

## Timing
- Reset values: SR=0, Cause=0, EPC=0, so CP0Out=0 (PRID at address 15), EPCOut=0 and Req=0.
- Reset asserted mid-handler clears EXL and EPC at once, asynchronously.
- Req latency: 0 cycles. It is combinational from the M-stage inputs and SR, and must settle within the same cycle so the PC loads 0x4180 at the next edge. CP0 latches at that same edge.
- Cause.IP lags HWInt by one cycle. Req uses live HWInt, not Cause.IP.
- EPCOut is registered; an `eret` one cycle after `mtc0 EPC` sees the new value.
- An `mtc0` to SR that sets IE with a pending masked line raises Req from the next cycle, not the write cycle.

## Test plan
- Reset then `mfc0` 12/13/14/15: reads 0, 0, 0, 0x0000_2024; Req=0.
- `mtc0` SR=0x0000_0401 with HWInt=6'b000001:
  - Req=1 in the next cycle.
  - After the edge with VPC=0x3010, BDIn=0: EPC=0x3010, EXL=1, ExcCode=0, Req drops to 0.
- EXL=0, IE=0, ExcCodeIn=12 (Ov), VPC=0x3024, BDIn=1:
  - Req=1.
  - After the edge: EPC=0x3020, Cause=0x8000_0030 (BD=1, ExcCode=12).
- Same-cycle interrupt and ExcCodeIn=4 with an `mtc0 EPC` pending:
  - ExcCode=0.
  - EPC=VPC, and the mtc0 write is dropped.
- In handler (EXL=1), HWInt active and ExcCodeIn=10: Req stays 0. Then EXLClr=1: EXL=0, and Req reasserts the following cycle if the line is still high.
- Async reset pulse between clock edges while EXL=1: SR, Cause, EPC read 0 before the next edge.

Source files
------------

// File: rtl/cp0.sv
// Coprocessor 0 for the pipelined MIPS core.
// Holds SR, Cause and EPC. Raises the fetch redirect (Req) for interrupts
// and M-stage exceptions, and services mtc0/mfc0 accesses.
module cp0 #(
  parameter logic [31:0] PRID = 32'h0000_2024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] CP0Out,
  output logic [31:0] EPCOut,
  output logic        Req
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // SR fields
  logic [5:0]  im;
  logic        exl;
  logic        ie;
  // Cause fields
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  // Exception PC
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic [31:0] victim_epc;
  logic        wr_sr;
  logic        wr_epc;

  // CP0In bits that have no backing register in SR.
  logic        unused_cp0in;
  assign unused_cp0in = ^{CP0In[31:16], CP0In[9:2]};

  // Interrupts use the live HWInt lines, not Cause.IP, so Req settles in the
  // same cycle and the PC can load the vector on the next edge. EXL masks both
  // sources so a handler is never re-entered.
  assign int_req = ~exl & ie & (|(HWInt & im));
  assign exc_req = ~exl & (ExcCodeIn != 5'd0);
  assign Req     = int_req | exc_req;

  // A delay-slot victim restarts at the branch so the branch is re-executed.
  assign victim_epc = BDIn ? (VPC - 32'd4) : VPC;

  // Software writes only land when no redirect is taken this edge.
  assign wr_sr  = en & ~Req & (CP0Add == ADDR_SR);
  assign wr_epc = en & ~Req & (CP0Add == ADDR_EPC);

  assign sr_word    = {16'd0, im, 8'd0, exl, ie};
  assign cause_word = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
  assign EPCOut     = epc;

  // mfc0 read mux; reflects registered state only, no write-through.
  always_comb begin
    CP0Out = 32'd0;
    case (CP0Add)
      ADDR_SR:    CP0Out = sr_word;
      ADDR_CAUSE: CP0Out = cause_word;
      ADDR_EPC:   CP0Out = epc;
      ADDR_PRID:  CP0Out = PRID;
      default:    CP0Out = 32'd0;
    endcase
  end

  // SR update: redirect sets EXL; otherwise eret clears EXL, and an mtc0 to
  // SR in the same cycle overrides the EXL bit because it is applied last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im  <= 6'd0;
      exl <= 1'b0;
      ie  <= 1'b0;
    end else if (Req) begin
      exl <= 1'b1;
    end else begin
      if (EXLClr) exl <= 1'b0;
      if (wr_sr) begin
        im  <= CP0In[15:10];
        exl <= CP0In[1];
        ie  <= CP0In[0];
      end
    end
  end

  // Cause update: IP samples the lines every edge; BD/ExcCode latch on redirect.
  // An interrupt takes priority, so the pipelined exception code is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ip       <= 6'd0;
      bd       <= 1'b0;
      exc_code <= 5'd0;
    end else begin
      ip <= HWInt;
      if (Req) begin
        bd       <= BDIn;
        exc_code <= int_req ? 5'd0 : ExcCodeIn;
      end
    end
  end

  // EPC update: victim PC on redirect, otherwise mtc0 to EPC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      epc <= 32'd0;
    end else if (Req) begin
      epc <= victim_epc;
    end else if (wr_epc) begin
      epc <= CP0In;
    end
  end

endmodule
